// File: rtl/ej32_fetch.sv
// eJ32 instruction-fetch stage: a byte prefetch queue fed by a single-outstanding
// memory request, flushed and re-pointed by branch redirects.
module ej32_fetch #(
  parameter int ASZ   = 17,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           br_psel,
  input  logic [ASZ-1:0] br_p,
  input  logic           dec_pop,
  input  logic           mem_ack,
  input  logic [7:0]     mem_data,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_addr,
  output logic           byte_v,
  output logic [7:0]     byte_o,
  output logic [ASZ-1:0] p_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e         state_q, state_d;
  logic [ASZ-1:0] fa_q, fa_d;
  logic           mem_req_q, mem_req_d;
  logic [ASZ-1:0] mem_addr_q, mem_addr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [ASZ-1:0] p_q, p_d;
  logic [7:0]     buf_q [DEPTH];

  logic pop;
  logic push;

  // NOTE: every signal assigned below gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fa_d       = fa_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    p_d        = p_q;

    pop     = dec_pop && (count_q != '0);
    push    = !br_psel && (state_q == S_WAIT) && mem_ack;
    count_d = count_q + CW'(push) - CW'(pop);

    if (br_psel) begin
      // A redirect wins over any same-cycle pop or push.
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      p_d     = br_p;
      fa_d    = br_p;
      if (state_q != S_IDLE) begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_DROP;
        end
      end
    end else begin
      if (pop) begin
        rd_d = rd_q + PW'(1);
        p_d  = p_q + ASZ'(1);
      end
      if (push) begin
        wr_d = wr_q + PW'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (count_q < FULL) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fa_q;
            fa_d       = fa_q + ASZ'(1);
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (count_d < FULL) begin
              mem_addr_d = fa_q;
              fa_d       = fa_q + ASZ'(1);
            end else begin
              mem_req_d = 1'b0;
              state_d   = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fa_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      p_q        <= '0;
    end else begin
      state_q    <= state_d;
      fa_q       <= fa_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      p_q        <= p_d;
    end
  end

  // NOTE: the byte storage is deliberately not reset; its contents are only
  // observable through byte_o, which is masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_q] <= mem_data;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign byte_v   = (count_q != '0);
  assign byte_o   = byte_v ? buf_q[rd_q] : 8'h00;
  assign p_o      = p_q;

endmodule

// File: tb/tb_ej32_fetch.sv
// Directed bench for ej32_fetch: a transaction-level queue model is checked
// against the DUT after every clock, plus literal expectations per scenario.
module tb_ej32_fetch;

  localparam int ASZ   = 17;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           br_psel;
  logic [ASZ-1:0] br_p;
  logic           dec_pop;
  logic           mem_ack;
  logic [7:0]     mem_data;
  logic           mem_req;
  logic [ASZ-1:0] mem_addr;
  logic           byte_v;
  logic [7:0]     byte_o;
  logic [ASZ-1:0] p_o;

  ej32_fetch #(.ASZ(ASZ), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_psel  (br_psel),
    .br_p     (br_p),
    .dec_pop  (dec_pop),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .byte_v   (byte_v),
    .byte_o   (byte_o),
    .p_o      (p_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder settings.
  bit auto_mem  = 1'b1;
  int ack_delay = 1;
  int wait_cnt  = 0;

  // Model: the queue contents, the instruction pointer, the next fetch address
  // and the one request that may be in flight (possibly made stale by a redirect).
  logic [7:0]     mq[$];
  logic [ASZ-1:0] m_p;
  logic [ASZ-1:0] m_fa;
  logic [ASZ-1:0] m_oaddr;
  bit             m_out;
  bit             m_stale;

  function automatic logic [7:0] mem_byte(input logic [ASZ-1:0] a);
    return 8'h10 + a[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_p     = '0;
    m_fa    = '0;
    m_oaddr = '0;
    m_out   = 1'b0;
    m_stale = 1'b0;
  endtask

  task automatic model_step();
    int  n0;
    bit  take;
    n0   = mq.size();
    take = dec_pop && (n0 > 0);
    if (br_psel) begin
      mq.delete();
      m_p  = br_p;
      m_fa = br_p;
      if (m_out) begin
        if (mem_ack) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (m_out) begin
      if (take) begin
        void'(mq.pop_front());
        m_p = m_p + 1'b1;
      end
      if (mem_ack) begin
        if (m_stale) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          mq.push_back(mem_data);
          if (mq.size() < DEPTH) begin
            m_oaddr = m_fa;
            m_fa    = m_fa + 1'b1;
          end else begin
            m_out = 1'b0;
          end
        end
      end
    end else begin
      if (n0 < DEPTH) begin
        m_out   = 1'b1;
        m_oaddr = m_fa;
        m_fa    = m_fa + 1'b1;
      end
      if (take) begin
        void'(mq.pop_front());
        m_p = m_p + 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("mem_req", {31'd0, mem_req}, {31'd0, m_out});
    if (m_out) check("mem_addr", {15'd0, mem_addr}, {15'd0, m_oaddr});
    check("byte_v", {31'd0, byte_v}, (mq.size() != 0) ? 32'd1 : 32'd0);
    check("byte_o", {24'd0, byte_o}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
    check("p_o", {15'd0, p_o}, {15'd0, m_p});
  endtask

  // Called at a negedge: drive inputs and the memory response, clock once,
  // step the model, compare, and return at the next negedge.
  task automatic tick(input logic pop, input logic psel, input logic [ASZ-1:0] bp,
                      input logic fack);
    dec_pop = pop;
    br_psel = psel;
    br_p    = bp;
    if (fack) begin
      mem_ack  = 1'b1;
      mem_data = mem_byte(mem_addr);
      wait_cnt = 0;
    end else if (!auto_mem || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt + 1 >= ack_delay) begin
      mem_ack  = 1'b1;
      mem_data = mem_byte(mem_addr);
      wait_cnt = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt++;
    end
    @(posedge clk);
    if (rst) model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    br_psel  = 1'b0;
    br_p     = '0;
    dec_pop  = 1'b0;
    mem_ack  = 1'b0;
    mem_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    check("reset_mem_addr", {15'd0, mem_addr}, 32'd0);
    check("reset_byte_v", {31'd0, byte_v}, 32'd0);
    rst = 1'b1;

    // Fill from address 0 with a one-cycle memory.
    tick(0, 0, '0, 0);
    check("fill_addr0", {15'd0, mem_addr}, 32'h0);
    tick(0, 0, '0, 0);
    check("fill_addr1", {15'd0, mem_addr}, 32'h1);
    tick(0, 0, '0, 0);
    check("fill_addr2", {15'd0, mem_addr}, 32'h2);
    tick(0, 0, '0, 0);
    check("fill_addr3", {15'd0, mem_addr}, 32'h3);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    check("full_req", {31'd0, mem_req}, 32'd0);
    check("full_byte", {24'd0, byte_o}, 32'h10);
    check("full_p", {15'd0, p_o}, 32'h0);
    check("full_v", {31'd0, byte_v}, 32'd1);
    check("model_count", mq.size(), 32'd4);

    // One pop from a full queue, then a single refill request.
    tick(1, 0, '0, 0);
    check("pop_byte", {24'd0, byte_o}, 32'h11);
    check("pop_p", {15'd0, p_o}, 32'h1);
    tick(0, 0, '0, 0);
    check("refill_req", {31'd0, mem_req}, 32'd1);
    check("refill_addr", {15'd0, mem_addr}, 32'h4);
    tick(0, 0, '0, 0);

    // Redirect while idle and full.
    tick(0, 1, 17'h01234, 0);
    check("rd1_empty", {31'd0, byte_v}, 32'd0);
    check("rd1_p", {15'd0, p_o}, 32'h1234);
    tick(0, 0, '0, 0);
    check("rd1_addr", {15'd0, mem_addr}, 32'h1234);
    tick(0, 0, '0, 0);
    check("rd1_byte", {24'd0, byte_o}, 32'h44);
    check("rd1_pfirst", {15'd0, p_o}, 32'h1234);
    repeat (4) tick(0, 0, '0, 0);

    // Redirect while a slow request to 0x0005 is outstanding.
    ack_delay = 3;
    tick(0, 1, 17'h00005, 0);
    tick(0, 0, '0, 0);
    check("slow_addr", {15'd0, mem_addr}, 32'h5);
    tick(0, 1, 17'h00100, 0);
    check("drop_req_held", {31'd0, mem_req}, 32'd1);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    check("drop_no_byte", {31'd0, byte_v}, 32'd0);
    check("drop_req_done", {31'd0, mem_req}, 32'd0);
    ack_delay = 1;
    tick(0, 0, '0, 0);
    check("after_drop_addr", {15'd0, mem_addr}, 32'h100);
    tick(0, 0, '0, 0);
    check("after_drop_byte", {24'd0, byte_o}, 32'h10);
    check("after_drop_p", {15'd0, p_o}, 32'h100);

    // Redirect, ack and pop in the same cycle.
    auto_mem = 1'b0;
    tick(1, 1, 17'h00200, 1);
    check("tri_v", {31'd0, byte_v}, 32'd0);
    check("tri_byte", {24'd0, byte_o}, 32'h0);
    check("tri_p", {15'd0, p_o}, 32'h200);
    check("tri_req", {31'd0, mem_req}, 32'd0);
    tick(0, 0, '0, 0);
    check("tri_issue", {15'd0, mem_addr}, 32'h200);

    // Fetch and consume across the address wrap.
    auto_mem = 1'b1;
    tick(0, 1, 17'h1FFFE, 0);
    tick(0, 0, '0, 0);
    check("wrap_a0", {15'd0, mem_addr}, 32'h1FFFE);
    tick(0, 0, '0, 0);
    check("wrap_a1", {15'd0, mem_addr}, 32'h1FFFF);
    tick(0, 0, '0, 0);
    check("wrap_a2", {15'd0, mem_addr}, 32'h00000);
    tick(1, 0, '0, 0);
    check("wrap_p1", {15'd0, p_o}, 32'h1FFFF);
    tick(1, 0, '0, 0);
    check("wrap_p2", {15'd0, p_o}, 32'h00000);
    tick(1, 0, '0, 0);
    check("wrap_p3", {15'd0, p_o}, 32'h00001);
    check("wrap_byte", {24'd0, byte_o}, 32'h11);

    // Asynchronous reset while a request is outstanding, then a stray ack.
    auto_mem = 1'b0;
    tick(0, 0, '0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_addr", {15'd0, mem_addr}, 32'd0);
    check("arst_v", {31'd0, byte_v}, 32'd0);
    check("arst_byte", {24'd0, byte_o}, 32'd0);
    check("arst_p", {15'd0, p_o}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    tick(0, 0, '0, 1);
    check("stray_v", {31'd0, byte_v}, 32'd0);
    check("stray_req", {31'd0, mem_req}, 32'd1);
    check("stray_addr", {15'd0, mem_addr}, 32'd0);

    // Steady streaming with interleaved pops.
    auto_mem = 1'b1;
    for (int i = 0; i < 10; i++) tick(logic'(i % 2), 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ej32_fetch.md
Name: ej32_fetch

Overview:
- Instruction-fetch stage of eJ32. Sits directly upstream of the branching unit and decoder.
- Fetches bytecode bytes from the memory bus into a small prefetch queue. Presents the head byte and its address (the `data` byte and `p` seen by the branching unit).
- Accepts redirects from the branching unit (br_psel with target br_p), which flush the queue and restart fetch at the target.

Parameters:
- ASZ, 17, instruction address width in bits.
- DEPTH, 4, prefetch queue depth in bytes; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- br_psel  in  1  redirect strobe from the branching unit; sampled each posedge.
- br_p  in  ASZ  redirect target address, valid when br_psel=1.
- dec_pop  in  1  decoder consumes the head byte this cycle.
- mem_ack  in  1  one-cycle pulse: mem_data is valid for the outstanding request.
- mem_data  in  8  fetched byte.
- mem_req  out  1  fetch request, registered; held until mem_ack.
- mem_addr  out  ASZ  fetch address, registered; stable while mem_req=1.
- byte_v  out  1  queue head valid (queue not empty).
- byte_o  out  8  queue head byte; 0 when empty.
- p_o  out  ASZ  address of the queue head byte (the instruction pointer).

Behaviour:
- Reset (rst=0, asynchronous): mem_req=0, mem_addr=0, byte_v=0, byte_o=0, p_o=0, fetch address fa=0, queue empty (count=0, rd/wr pointers=0), FSM=IDLE.
- Queue:
  - Circular buffer of DEPTH bytes with rd/wr pointers modulo DEPTH and count in 0..DEPTH.
  - byte_v=(count!=0); byte_o=buf[rd]; both are driven from registers, with no combinational path from inputs.
- Pop:
  - dec_pop=1 with byte_v=1: rd+1, count-1, p_o+1.
  - dec_pop with byte_v=0 is ignored: no state change.
- Address arithmetic: fa, mem_addr and p_o are all ASZ bits and wrap 2^ASZ-1 -> 0.
- Single outstanding request. FSM states:
  - IDLE (no request outstanding):
    - If no redirect and count < DEPTH: next cycle mem_req=1, mem_addr=fa; fa<=fa+1; go to WAIT.
    - Otherwise stay in IDLE with mem_req=0.
  - WAIT (request outstanding):
    - On mem_ack without redirect: push mem_data at wr; wr+1; count+1 (net of any same-cycle pop).
    - If room remains after this cycle's push/pop (count_next < DEPTH): keep mem_req=1, mem_addr<=fa, fa<=fa+1, stay in WAIT (back-to-back fetch).
    - Else: mem_req<=0 and go to IDLE.
  - DROP (request outstanding, response stale):
    - mem_req stays high until ack. The ack data is discarded, no push.
    - On ack: mem_req<=0, go to IDLE.
- Redirect (br_psel=1 at a posedge):
  - Queue is flushed (count=0, rd=wr=0).
  - p_o<=br_p; fa<=br_p.
  - From IDLE: stay in IDLE; issue at the following cycle.
  - From WAIT without ack: go to DROP.
  - From WAIT with ack in the same cycle: ack data dropped, mem_req<=0, go to IDLE.
  - From DROP: stay in DROP, or go to IDLE if ack arrives in the same cycle.
- Simultaneous events:
  - Redirect beats pop and push in the same cycle.
  - Pop and push in the same cycle: count unchanged; both pointers advance.
  - Push with count=DEPTH cannot occur, because requests are issued only when a slot is free (count + outstanding <= DEPTH).
- Latency:
  - Redirect sampled at edge N: mem_req/mem_addr=br_p visible after edge N+1.
  - With mem_ack at edge N+2: byte_v=1, byte_o=that byte, p_o=br_p after edge N+2.
  - Steady-state throughput with single-cycle memory: 1 byte per cycle.
- Reset mid-request: everything returns to reset values immediately. A late mem_ack arriving in IDLE is ignored.
- mem_ack in IDLE is always ignored.

Test Plan:
- Reset then release, with memory acking 1 cycle after req; mem[0..3]=10,11,12,13 and dec_pop=0 -> mem_addr 0,1,2,3; count reaches 4; mem_req drops; byte_o=10, p_o=0, byte_v=1.
- Full queue, then dec_pop for 1 cycle -> byte_o=11, p_o=1; one new request to mem_addr=4 issued the next cycle.
- Redirect br_p=0x1234 while IDLE with queue full -> queue empty next cycle; mem_addr=0x1234, then byte_o=mem[0x1234], p_o=0x1234.
- Redirect br_p=0x0100 while a request to 0x0005 is outstanding (ack delayed 3 cycles) -> FSM enters DROP; the 0x0005 byte never appears; next request is 0x0100.
- Redirect, ack and dec_pop all in the same cycle -> ack byte dropped, queue empty, p_o=br_p, FSM=IDLE.
- Fetch across the wrap: redirect to 0x1FFFE with ASZ=17 -> mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000; p_o wraps identically on pops.
- Assert rst=0 mid-WAIT -> all outputs 0 asynchronously; a stray mem_ack after release is ignored.
